array_rw_sched: RTL and testbench

Frame scheduler placed ahead of the array write and read engines. It accepts one upstream frame stream carrying both write and read bursts, and routes each sof..eof burst to the correct engine. It pulses the engine's start and waits for its done. It then inserts a programmable turnaround gap before the next burst, so the two engines never drive the array interface at the same time.

---
 rtl/array_rw_sched.sv | 192 +++++++++++++++++++
 tb/tb_array_rw_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_rw_sched.sv
// array_rw_sched: routes sof..eof bursts from one upstream frame stream to the write or read engine.
// Latency: 1 cycle from sof valid to engine valid (the sof beat waits one IDLE cycle), then 0-cycle pass-through.
// Backpressure: frame_ready mirrors the selected engine's ready in a burst, 0 in WAIT_DONE/GAP and on a held sof.
// Optional feature: define ARRAY_SCHED_WDOG_EN to build the WAIT_DONE watchdog (err_timeout).
module array_rw_sched #(
  parameter int ARRAY_COL_ADDR_WIDTH   = 6,
  parameter int ARRAY_ROW_ADDR_WIDTH   = 16,
  parameter int ARRAY_DATA_WIDTH       = 64,
  parameter int ARRAY_FRAME_DATA_WIDTH = 3 + ARRAY_COL_ADDR_WIDTH + ARRAY_ROW_ADDR_WIDTH + ARRAY_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_valid,
  input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] frame_data,
  output logic                              frame_ready,
  output logic                              array_wframe_valid,
  output logic [ARRAY_FRAME_DATA_WIDTH-1:0] array_wframe_data,
  input  logic                              array_wframe_ready,
  output logic                              array_wr_start,
  input  logic                              array_wr_done,
  output logic                              array_rframe_valid,
  output logic [ARRAY_FRAME_DATA_WIDTH-1:0] array_rframe_data,
  input  logic                              array_rframe_ready,
  output logic                              array_rd_start,
  input  logic                              array_rd_done,
  input  logic [7:0]                        array_tTA,
  output logic                              sched_busy,
  output logic                              err_proto,
  output logic                              err_timeout
);

  // Frame control bits sit above caddr/raddr/data.
  localparam int RW_BIT  = ARRAY_COL_ADDR_WIDTH + ARRAY_ROW_ADDR_WIDTH + ARRAY_DATA_WIDTH;
  localparam int SOF_BIT = RW_BIT + 1;
  localparam int EOF_BIT = RW_BIT + 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_BURST  = 3'd1,
    S_RD_BURST  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t     r_state;
  logic       r_rw_flag;     // 1 = current burst is a write
  logic       r_first_beat;  // no beat of the current burst accepted yet
  logic       r_wr_start;
  logic       r_rd_start;
  logic       r_err_proto;
  logic [7:0] r_gap_cnt;

  logic w_in_wr;
  logic w_in_rd;
  logic w_in_burst;
  logic w_beat_rw;
  logic w_beat_sof;
  logic w_beat_eof;
  logic w_sel_rdy;
  logic w_accept;
  logic w_lat_done;
  logic w_oth_done;
  logic w_frame_ready;

  assign w_in_wr    = (r_state == S_WR_BURST);
  assign w_in_rd    = (r_state == S_RD_BURST);
  assign w_in_burst = w_in_wr | w_in_rd;
  assign w_beat_rw  = frame_data[RW_BIT];
  assign w_beat_sof = frame_data[SOF_BIT];
  assign w_beat_eof = frame_data[EOF_BIT];
  assign w_sel_rdy  = w_in_wr ? array_wframe_ready : array_rframe_ready;
  assign w_accept   = w_in_burst & frame_valid & w_sel_rdy;
  assign w_lat_done = r_rw_flag ? array_wr_done : array_rd_done;
  assign w_oth_done = r_rw_flag ? array_rd_done : array_wr_done;

`ifdef ARRAY_SCHED_WDOG_EN
  logic [9:0] r_wdog_cnt;
  logic       r_err_timeout;
  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

  // Burst FSM: state, latched direction, start pulses, gap counter and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rw_flag    <= 1'b0;
      r_first_beat <= 1'b0;
      r_wr_start   <= 1'b0;
      r_rd_start   <= 1'b0;
      r_err_proto  <= 1'b0;
      r_gap_cnt    <= 8'd0;
`ifdef ARRAY_SCHED_WDOG_EN
      r_wdog_cnt    <= 10'd0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_valid) begin
            if (w_beat_sof) begin
              // Hold the sof beat upstream; it is forwarded next cycle with the start pulse.
              r_rw_flag    <= w_beat_rw;
              r_first_beat <= 1'b1;
              r_wr_start   <= w_beat_rw;
              r_rd_start   <= ~w_beat_rw;
              r_state      <= w_beat_rw ? S_WR_BURST : S_RD_BURST;
            end else begin
              // Stray beat outside a burst is consumed and dropped.
              r_err_proto <= 1'b1;
            end
          end
        end
        S_WR_BURST, S_RD_BURST: begin
          if (array_wr_done | array_rd_done) begin
            r_err_proto <= 1'b1;
          end
          if (w_accept) begin
            r_first_beat <= 1'b0;
            if ((w_beat_sof & ~r_first_beat) | (w_beat_rw != r_rw_flag)) begin
              r_err_proto <= 1'b1;
            end
            if (w_beat_eof) begin
              r_state <= S_WAIT_DONE;
`ifdef ARRAY_SCHED_WDOG_EN
              r_wdog_cnt <= 10'd0;
`endif
            end
          end
        end
        S_WAIT_DONE: begin
          if (w_oth_done) begin
            r_err_proto <= 1'b1;
          end
          if (w_lat_done) begin
            if (array_tTA != 8'd0) begin
              r_gap_cnt <= array_tTA;
              r_state   <= S_GAP;
            end else begin
              r_state <= S_IDLE;
            end
          end
`ifdef ARRAY_SCHED_WDOG_EN
          else if (r_wdog_cnt == 10'd1023) begin
            // Engine never answered: give up on this burst without a gap.
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 10'd1;
          end
`endif
        end
        S_GAP: begin
          if (r_gap_cnt == 8'd1) begin
            r_gap_cnt <= 8'd0;
            r_state   <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Upstream ready: follow the selected engine in a burst, swallow stray beats in IDLE.
  always_comb begin
    w_frame_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:     w_frame_ready = frame_valid & ~w_beat_sof;
        S_WR_BURST: w_frame_ready = array_wframe_ready;
        S_RD_BURST: w_frame_ready = array_rframe_ready;
        default:    w_frame_ready = 1'b0;
      endcase
    end
  end

  assign frame_ready        = w_frame_ready;
  assign array_wframe_valid = w_in_wr & frame_valid;
  assign array_rframe_valid = w_in_rd & frame_valid;
  assign array_wframe_data  = w_in_wr ? frame_data : '0;
  assign array_rframe_data  = w_in_rd ? frame_data : '0;
  assign array_wr_start     = r_wr_start;
  assign array_rd_start     = r_rd_start;
  assign sched_busy         = (r_state != S_IDLE);
  assign err_proto          = r_err_proto;

endmodule

// File: tb/tb_array_rw_sched.sv
// Directed bench for array_rw_sched: burst routing, turnaround timing, backpressure, errors, reset, no-done hang.
module tb_array_rw_sched;

  localparam int FW = 89;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          frame_ready;
  logic          array_wframe_valid;
  logic [FW-1:0] array_wframe_data;
  logic          wr_rdy;
  logic          array_wr_start;
  logic          array_wr_done;
  logic          array_rframe_valid;
  logic [FW-1:0] array_rframe_data;
  logic          rd_rdy;
  logic          array_rd_start;
  logic          array_rd_done;
  logic [7:0]    array_tTA;
  logic          sched_busy;
  logic          err_proto;
  logic          err_timeout;

  logic          tog_en = 1'b0;
  logic          tog_rdy = 1'b1;
  wire           w_rframe_ready = tog_en ? tog_rdy : rd_rdy;

  array_rw_sched dut (
    .clk                (clk),
    .rst                (rst),
    .frame_valid        (frame_valid),
    .frame_data         (frame_data),
    .frame_ready        (frame_ready),
    .array_wframe_valid (array_wframe_valid),
    .array_wframe_data  (array_wframe_data),
    .array_wframe_ready (wr_rdy),
    .array_wr_start     (array_wr_start),
    .array_wr_done      (array_wr_done),
    .array_rframe_valid (array_rframe_valid),
    .array_rframe_data  (array_rframe_data),
    .array_rframe_ready (w_rframe_ready),
    .array_rd_start     (array_rd_start),
    .array_rd_done      (array_rd_done),
    .array_tTA          (array_tTA),
    .sched_busy         (sched_busy),
    .err_proto          (err_proto),
    .err_timeout        (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-engine ready pattern 1,0,0,1,0,0,... applied mid-cycle.
  int tog_idx = 0;
  always begin
    @(posedge clk);
    #2;
    if (tog_en) begin
      tog_rdy = (tog_idx % 3 == 0);
      tog_idx = tog_idx + 1;
    end
  end

  // Monitor: log engine-side beats and timing events.
  logic [FW-1:0] wlog [0:127];
  logic [FW-1:0] rlog [0:127];
  int wn = 0, rn = 0;
  int n_wstart = 0, n_rstart = 0, n_wstart_cv = 0, n_rstart_cv = 0;
  int n_overlap = 0, n_mirror_bad = 0;
  int t_wdone = 0, t_rstart = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (array_wframe_valid && wr_rdy && wn < 128) begin wlog[wn] = array_wframe_data; wn = wn + 1; end
      if (array_rframe_valid && w_rframe_ready && rn < 128) begin rlog[rn] = array_rframe_data; rn = rn + 1; end
      if (array_wr_start) n_wstart = n_wstart + 1;
      if (array_rd_start) begin n_rstart = n_rstart + 1; t_rstart = cyc; end
      if (array_wr_start && array_wframe_valid) n_wstart_cv = n_wstart_cv + 1;
      if (array_rd_start && array_rframe_valid) n_rstart_cv = n_rstart_cv + 1;
      if (array_wr_done) t_wdone = cyc;
      if (array_wframe_valid && array_rframe_valid) n_overlap = n_overlap + 1;
      if (array_rframe_valid && (frame_ready !== w_rframe_ready)) n_mirror_bad = n_mirror_bad + 1;
      if (array_wframe_valid && (frame_ready !== wr_rdy)) n_mirror_bad = n_mirror_bad + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [FW-1:0] mk(input logic eof, input logic sof, input logic rw,
                                       input logic [63:0] d, input logic [15:0] ra, input logic [5:0] ca);
    return {eof, sof, rw, d, ra, ca};
  endfunction

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [FW-1:0] d);
    logic acc = 1'b0;
    frame_valid = 1'b1;
    frame_data  = d;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      acc = frame_ready;
    end
    chk("handshake", {95'd0, acc}, 96'd1);
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
  endtask

  task automatic pulse_wr_done();
    array_wr_done = 1'b1;
    @(posedge clk); #1;
    array_wr_done = 1'b0;
  endtask

  task automatic pulse_rd_done();
    array_rd_done = 1'b1;
    @(posedge clk); #1;
    array_rd_done = 1'b0;
  endtask

  task automatic wait_idle();
    logic idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge clk);
      idle = !sched_busy;
    end
    chk("reach_idle", {95'd0, idle}, 96'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wvld"}, {95'd0, array_wframe_valid}, 96'd0);
    chk({tag, "_rvld"}, {95'd0, array_rframe_valid}, 96'd0);
    chk({tag, "_wdat"}, {7'd0, array_wframe_data}, 96'd0);
    chk({tag, "_rdat"}, {7'd0, array_rframe_data}, 96'd0);
    chk({tag, "_starts"}, {94'd0, array_wr_start, array_rd_start}, 96'd0);
    chk({tag, "_ready"}, {95'd0, frame_ready}, 96'd0);
    chk({tag, "_busy"}, {95'd0, sched_busy}, 96'd0);
    chk({tag, "_errs"}, {94'd0, err_proto, err_timeout}, 96'd0);
  endtask

  initial begin
    int wb, rb, ws, rs, wcv, rcv;
    rst = 1'b1; frame_valid = 1'b0; frame_data = '0;
    wr_rdy = 1'b1; rd_rdy = 1'b1;
    array_wr_done = 1'b0; array_rd_done = 1'b0; array_tTA = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: 8-beat write, tTA=6, done ~20 cycles after eof.
    array_tTA = 8'd6;
    wb = wn; rb = rn; ws = n_wstart; wcv = n_wstart_cv;
    for (int i = 0; i < 8; i++) send_beat(mk(i == 7, i == 0, 1'b1, 64'hA000 + i, 16'(i), 6'(i)));
    repeat (19) @(posedge clk);
    #1;
    array_wr_done = 1'b1;
    @(negedge clk);
    chk("t1_busy_at_done", {95'd0, sched_busy}, 96'd1);
    @(posedge clk); #1;
    array_wr_done = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t1_busy_done_plus6", {95'd0, sched_busy}, 96'd1);
    @(negedge clk);
    chk("t1_busy_done_plus7", {95'd0, sched_busy}, 96'd0);
    chk("t1_wr_beats", 96'(wn - wb), 96'd8);
    chk("t1_rd_beats", 96'(rn - rb), 96'd0);
    chk("t1_wr_start", 96'(n_wstart - ws), 96'd1);
    chk("t1_start_with_valid", 96'(n_wstart_cv - wcv), 96'd1);
    for (int i = 0; i < 8; i++)
      chk("t1_wdata", {7'd0, wlog[wb + i]}, {7'd0, mk(i == 7, i == 0, 1'b1, 64'hA000 + i, 16'(i), 6'(i))});
    chk("t1_err_proto", {95'd0, err_proto}, 96'd0);
    @(posedge clk); #1;

    // 2: 4-beat write then 4-beat read back to back, tTA=0.
    array_tTA = 8'd0;
    wb = wn; rb = rn; rs = n_rstart; rcv = n_rstart_cv;
    for (int i = 0; i < 4; i++) send_beat(mk(i == 3, i == 0, 1'b1, 64'hB000 + i, 16'h100, 6'(i)));
    fork
      begin
        for (int i = 0; i < 4; i++) send_beat(mk(i == 3, i == 0, 1'b0, 64'hC000 + i, 16'h200, 6'(i)));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        pulse_wr_done();
      end
    join
    pulse_rd_done();
    wait_idle();
    chk("t2_rd_start_after_done", 96'(t_rstart - t_wdone), 96'd2);
    chk("t2_rd_start_cnt", 96'(n_rstart - rs), 96'd1);
    chk("t2_rd_start_with_valid", 96'(n_rstart_cv - rcv), 96'd1);
    chk("t2_wr_beats", 96'(wn - wb), 96'd4);
    chk("t2_rd_beats", 96'(rn - rb), 96'd4);
    for (int i = 0; i < 4; i++)
      chk("t2_rdata", {7'd0, rlog[rb + i]}, {7'd0, mk(i == 3, i == 0, 1'b0, 64'hC000 + i, 16'h200, 6'(i))});

    // 3: 6-beat read with engine ready toggling 1,0,0,...
    rb = rn; wb = wn;
    tog_idx = 0;
    tog_en = 1'b1;
    for (int i = 0; i < 6; i++) send_beat(mk(i == 5, i == 0, 1'b0, 64'hD000 + i, 16'h300, 6'(i)));
    tog_en = 1'b0;
    pulse_rd_done();
    wait_idle();
    chk("t3_rd_beats", 96'(rn - rb), 96'd6);
    chk("t3_wr_beats", 96'(wn - wb), 96'd0);
    for (int i = 0; i < 6; i++)
      chk("t3_rdata", {7'd0, rlog[rb + i]}, {7'd0, mk(i == 5, i == 0, 1'b0, 64'hD000 + i, 16'h300, 6'(i))});
    chk("t3_ready_mirror", 96'(n_mirror_bad), 96'd0);
    chk("t3_err_proto", {95'd0, err_proto}, 96'd0);

    // 4: stray non-sof beat in IDLE, then rw mismatch inside a write burst.
    array_tTA = 8'd2;
    wb = wn; rb = rn;
    send_beat(mk(1'b0, 1'b0, 1'b1, 64'hEEEE, 16'h0, 6'h0));
    @(negedge clk);
    chk("t4_drop_err", {95'd0, err_proto}, 96'd1);
    chk("t4_drop_not_fwd", 96'((wn - wb) + (rn - rb)), 96'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_beat(mk(i == 3, i == 0, i != 2, 64'hF000 + i, 16'h400, 6'(i)));
    repeat (3) @(posedge clk);
    #1;
    pulse_wr_done();
    wait_idle();
    chk("t4_wr_beats", 96'(wn - wb), 96'd4);
    chk("t4_mismatch_fwd", {7'd0, wlog[wb + 2]}, {7'd0, mk(1'b0, 1'b0, 1'b0, 64'hF002, 16'h400, 6'd2)});
    chk("t4_err_sticky", {95'd0, err_proto}, 96'd1);

    // 5: reset at beat 3 of an 8-beat write, then a clean fresh burst.
    wb = wn;
    for (int i = 0; i < 3; i++) send_beat(mk(1'b0, i == 0, 1'b1, 64'h1000 + i, 16'h500, 6'(i)));
    frame_valid = 1'b1;
    frame_data  = mk(1'b0, 1'b0, 1'b1, 64'h1003, 16'h500, 6'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("t5_after_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_beats_before_rst", 96'(wn - wb), 96'd3);
    wb = wn; ws = n_wstart;
    for (int i = 0; i < 2; i++) send_beat(mk(i == 1, i == 0, 1'b1, 64'h2000 + i, 16'h600, 6'(i)));
    pulse_wr_done();
    wait_idle();
    chk("t5_fresh_beats", 96'(wn - wb), 96'd2);
    chk("t5_fresh_start", 96'(n_wstart - ws), 96'd1);
    chk("t5_fresh_data", {7'd0, wlog[wb]}, {7'd0, mk(1'b0, 1'b1, 1'b1, 64'h2000, 16'h600, 6'd0)});
    chk("t5_err_clean", {95'd0, err_proto}, 96'd0);

    // 6: write burst whose done never arrives.
    for (int i = 0; i < 2; i++) send_beat(mk(i == 1, i == 0, 1'b1, 64'h3000 + i, 16'h700, 6'(i)));
`ifdef ARRAY_SCHED_WDOG_EN
    repeat (1023) @(posedge clk);
    @(negedge clk);
    chk("t6_no_timeout_yet", {94'd0, err_timeout, sched_busy}, 96'd1);
    @(negedge clk);
    chk("t6_timeout_idle", {94'd0, err_timeout, sched_busy}, 96'd2);
`else
    repeat (1100) @(posedge clk);
    @(negedge clk);
    chk("t6_still_busy", {95'd0, sched_busy}, 96'd1);
    chk("t6_no_timeout", {95'd0, err_timeout}, 96'd0);
`endif
    chk("t6_overlap", 96'(n_overlap), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
